// File: rtl/game_screen_seq_pkg.sv
// Shared encodings for the game screen sequencer: phase codes, winner codes
// and the score ceiling.
package game_screen_pkg;

  typedef enum logic [1:0] {
    ST_TITLE = 2'b00,
    ST_PLAY  = 2'b01,
    ST_PAUSE = 2'b10,
    ST_OVER  = 2'b11
  } state_t;

  localparam logic [1:0] WIN_NONE  = 2'b00;
  localparam logic [1:0] WIN_LEFT  = 2'b01;
  localparam logic [1:0] WIN_RIGHT = 2'b10;
  localparam logic [1:0] WIN_DRAW  = 2'b11;

  localparam logic [3:0] SCORE_MAX = 4'd9;

  localparam bit EDGE_RISE = 1'b0;
  localparam bit EDGE_FALL = 1'b1;

  function automatic logic [1:0] decide_winner(input logic [3:0] sc_l, input logic [3:0] sc_r);
    logic [1:0] w_res;
    if (sc_l > sc_r) begin
      w_res = WIN_LEFT;
    end else if (sc_r > sc_l) begin
      w_res = WIN_RIGHT;
    end else begin
      w_res = WIN_DRAW;
    end
    return w_res;
  endfunction

endpackage

// File: rtl/game_screen_seq_edge_det.sv
// Single-flop edge detector: combinational 1-cycle pulse on the selected edge.
// History resets to 1 so a level already high at reset release never fires.
module edge_det
  import game_screen_pkg::*;
#(
  parameter bit POLARITY = EDGE_RISE
) (
  input  logic clk,
  input  logic rst,
  input  logic i_sig,
  output logic o_pulse
);

  logic r_prev;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_prev <= 1'b1;
    end else begin
      r_prev <= i_sig;
    end
  end

  generate
    if (POLARITY == EDGE_FALL) begin : g_fall
      assign o_pulse = r_prev & ~i_sig;
    end else begin : g_rise
      assign o_pulse = ~r_prev & i_sig;
    end
  endgenerate

endmodule

// File: rtl/game_screen_seq.sv
// Frame-synchronous game phase sequencer: phase FSM, scores, match clock and
// OVER hold timer. Phase changes only on the frame tick derived from vsync.
module game_screen_seq
  import game_screen_pkg::*;
#(
  parameter int FPS          = 60,
  parameter int GAME_SECONDS = 90,
  parameter int WIN_SCORE    = 5,
  parameter int OVER_FRAMES  = 180
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vsync,
  input  logic       btn_start,
  input  logic       btn_pause,
  input  logic       goal_l,
  input  logic       goal_r,
  output logic [1:0] screen_sel,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic [6:0] time_left,
  output logic [1:0] winner,
  output logic       frame_tick
);

  localparam int DIV_W  = (FPS > 1) ? $clog2(FPS) : 1;
  localparam int HOLD_W = $clog2(OVER_FRAMES + 1);

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(FPS - 1);
  localparam logic [HOLD_W-1:0] HOLD_DONE = HOLD_W'(OVER_FRAMES);
  localparam logic [6:0]        TIME_INIT = 7'(GAME_SECONDS);
  localparam logic [3:0]        WIN_LVL   = 4'(WIN_SCORE);

  logic              w_vs_fall;
  logic [1:0]        w_btn_level;
  logic [1:0]        w_btn_rise;
  logic              w_start_rise;
  logic              w_pause_rise;

  logic              r_frame_tick;
  logic              r_start_req;
  logic              r_pause_req;

  state_t            r_state;
  state_t            w_state_next;
  logic              w_match_start;
  logic              w_match_end;

  logic [3:0]        r_score_l;
  logic [3:0]        r_score_r;
  logic [3:0]        w_score_l_next;
  logic [3:0]        w_score_r_next;
  logic [1:0]        r_winner;

  logic [6:0]        r_time_left;
  logic [DIV_W-1:0]  r_sec_div;
  logic [HOLD_W-1:0] r_hold_cnt;

  edge_det #(
    .POLARITY (EDGE_FALL)
  ) u_vsync_edge (
    .clk     (clk),
    .rst     (rst),
    .i_sig   (vsync),
    .o_pulse (w_vs_fall)
  );

  // Bit 0 is start, bit 1 is pause; both want rising edges.
  assign w_btn_level = {btn_pause, btn_start};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_btn
      edge_det #(
        .POLARITY (EDGE_RISE)
      ) u_btn_edge (
        .clk     (clk),
        .rst     (rst),
        .i_sig   (w_btn_level[gi]),
        .o_pulse (w_btn_rise[gi])
      );
    end
  endgenerate

  assign w_start_rise = w_btn_rise[0];
  assign w_pause_rise = w_btn_rise[1];

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_frame_tick <= 1'b0;
    end else begin
      r_frame_tick <= w_vs_fall;
    end
  end

  // Requests live for one frame; an edge landing on the tick cycle carries over.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_start_req <= 1'b0;
      r_pause_req <= 1'b0;
    end else if (r_frame_tick) begin
      r_start_req <= w_start_rise;
      r_pause_req <= w_pause_rise;
    end else begin
      r_start_req <= r_start_req | w_start_rise;
      r_pause_req <= r_pause_req | w_pause_rise;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_TITLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_match_start = 1'b0;
    w_match_end   = 1'b0;
    if (r_frame_tick) begin
      case (r_state)
        ST_TITLE: begin
          if (r_start_req) begin
            w_state_next  = ST_PLAY;
            w_match_start = 1'b1;
          end
        end
        ST_PLAY: begin
          // End-of-match wins over a pause request in the same frame.
          if ((r_score_l >= WIN_LVL) || (r_score_r >= WIN_LVL) || (r_time_left == '0)) begin
            w_state_next = ST_OVER;
            w_match_end  = 1'b1;
          end else if (r_pause_req) begin
            w_state_next = ST_PAUSE;
          end
        end
        ST_PAUSE: begin
          if (r_pause_req || r_start_req) begin
            w_state_next = ST_PLAY;
          end
        end
        ST_OVER: begin
          if ((r_hold_cnt == HOLD_DONE) && r_start_req) begin
            w_state_next = ST_TITLE;
          end
        end
        default: begin
          w_state_next = ST_TITLE;
        end
      endcase
    end
  end

  always_comb begin
    w_score_l_next = r_score_l;
    w_score_r_next = r_score_r;
    if (r_state == ST_PLAY) begin
      if (goal_l && (r_score_l < SCORE_MAX)) begin
        w_score_l_next = r_score_l + 4'd1;
      end
      if (goal_r && (r_score_r < SCORE_MAX)) begin
        w_score_r_next = r_score_r + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_score_l <= 4'd0;
      r_score_r <= 4'd0;
    end else if (w_match_start) begin
      r_score_l <= 4'd0;
      r_score_r <= 4'd0;
    end else begin
      r_score_l <= w_score_l_next;
      r_score_r <= w_score_r_next;
    end
  end

  // Judged on the post-goal score so a goal on the final tick is not lost.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_winner <= WIN_NONE;
    end else if (w_match_start) begin
      r_winner <= WIN_NONE;
    end else if (w_match_end) begin
      r_winner <= decide_winner(w_score_l_next, w_score_r_next);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_time_left <= TIME_INIT;
      r_sec_div   <= '0;
    end else if (w_match_start) begin
      r_time_left <= TIME_INIT;
      r_sec_div   <= '0;
    end else if (r_frame_tick && (r_state == ST_PLAY) && (r_time_left != '0)) begin
      if (r_sec_div == DIV_LAST) begin
        r_sec_div   <= '0;
        r_time_left <= r_time_left - 7'd1;
      end else begin
        r_sec_div <= r_sec_div + DIV_W'(1);
      end
    end
  end

  // Counts ticks spent in OVER, saturating at the hold length.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_hold_cnt <= '0;
    end else if (r_state != ST_OVER) begin
      r_hold_cnt <= '0;
    end else if (r_frame_tick && (r_hold_cnt != HOLD_DONE)) begin
      r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
    end
  end

  assign screen_sel = r_state;
  assign score_l    = r_score_l;
  assign score_r    = r_score_r;
  assign time_left  = r_time_left;
  assign winner     = r_winner;
  assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_game_screen_seq.sv
// Frame-level bench for game_screen_seq: table of per-frame stimulus with
// expected post-tick outputs, checked through a scoreboard queue.
module tb_game_screen_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       vsync = 1'b1;
  logic       btn_start = 1'b0;
  logic       btn_pause = 1'b0;
  logic       goal_l = 1'b0;
  logic       goal_r = 1'b0;
  logic [1:0] screen_sel;
  logic [3:0] score_l;
  logic [3:0] score_r;
  logic [6:0] time_left;
  logic [1:0] winner;
  logic       frame_tick;

  logic       rst2 = 1'b0;
  logic       vsync2 = 1'b1;
  logic       btn_start2 = 1'b0;
  logic       btn_pause2 = 1'b0;
  logic       goal_l2 = 1'b0;
  logic       goal_r2 = 1'b0;
  logic [1:0] screen_sel2;
  logic [3:0] score_l2;
  logic [3:0] score_r2;
  logic [6:0] time_left2;
  logic [1:0] winner2;
  logic       frame_tick2;

  always #5 clk = ~clk;

  game_screen_seq #(
    .FPS(2), .GAME_SECONDS(3), .WIN_SCORE(2), .OVER_FRAMES(4)
  ) dut (
    .clk(clk), .rst(rst), .vsync(vsync), .btn_start(btn_start), .btn_pause(btn_pause),
    .goal_l(goal_l), .goal_r(goal_r), .screen_sel(screen_sel), .score_l(score_l),
    .score_r(score_r), .time_left(time_left), .winner(winner), .frame_tick(frame_tick)
  );

  game_screen_seq #(
    .FPS(2), .GAME_SECONDS(3), .WIN_SCORE(9), .OVER_FRAMES(4)
  ) dut9 (
    .clk(clk), .rst(rst2), .vsync(vsync2), .btn_start(btn_start2), .btn_pause(btn_pause2),
    .goal_l(goal_l2), .goal_r(goal_r2), .screen_sel(screen_sel2), .score_l(score_l2),
    .score_r(score_r2), .time_left(time_left2), .winner(winner2), .frame_tick(frame_tick2)
  );

  typedef struct {
    bit start;
    bit pause;
    int gl;
    int gr;
    int sel;
    int sl;
    int sr;
    int tl;
    int win;
  } vec_t;

  typedef struct {
    int idx;
    int sel;
    int sl;
    int sr;
    int tl;
    int win;
  } exp_t;

  vec_t vq[$];
  exp_t sb_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;
  int   tick_count = 0;
  int   last_sel = 0;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic add(input bit st, input bit pa, input int gl, input int gr,
                     input int sel, input int sl, input int sr, input int tl, input int win);
    vec_t v;
    v.start = st; v.pause = pa; v.gl = gl; v.gr = gr;
    v.sel = sel; v.sl = sl; v.sr = sr; v.tl = tl; v.win = win;
    vq.push_back(v);
  endtask

  // Scoreboard consumer: one entry per frame tick, compared once state settles.
  always begin
    @(negedge clk);
    if (frame_tick === 1'b1) begin
      tick_count++;
      @(negedge clk);
      if (sb_q.size() > 0) begin
        mon_e = sb_q.pop_front();
        $display("frame %0d: sel=%0d score=%0d:%0d time=%0d winner=%0d",
                 mon_e.idx, screen_sel, score_l, score_r, time_left, winner);
        check($sformatf("sel[%0d]", mon_e.idx), int'(screen_sel), mon_e.sel);
        check($sformatf("score_l[%0d]", mon_e.idx), int'(score_l), mon_e.sl);
        check($sformatf("score_r[%0d]", mon_e.idx), int'(score_r), mon_e.sr);
        check($sformatf("time_left[%0d]", mon_e.idx), int'(time_left), mon_e.tl);
        check($sformatf("winner[%0d]", mon_e.idx), int'(winner), mon_e.win);
        last_sel = mon_e.sel;
      end
    end
  end

  task automatic run_frame(input vec_t v, input int idx);
    exp_t e;
    int   t0;
    int   ng;
    repeat (3) @(negedge clk);
    check($sformatf("pre_tick_sel[%0d]", idx), int'(screen_sel), last_sel);
    btn_start = v.start;
    btn_pause = v.pause;
    repeat (2) @(negedge clk);
    btn_start = 1'b0;
    btn_pause = 1'b0;
    ng = (v.gl > v.gr) ? v.gl : v.gr;
    for (int i = 0; i < ng; i++) begin
      goal_l = (i < v.gl);
      goal_r = (i < v.gr);
      @(negedge clk);
      goal_l = 1'b0;
      goal_r = 1'b0;
      @(negedge clk);
    end
    e.idx = idx; e.sel = v.sel; e.sl = v.sl; e.sr = v.sr; e.tl = v.tl; e.win = v.win;
    sb_q.push_back(e);
    t0 = tick_count;
    vsync = 1'b0;
    @(negedge clk);
    check($sformatf("tick_latency[%0d]", idx), int'(frame_tick), 1);
    @(negedge clk);
    vsync = 1'b1;
    repeat (4) @(negedge clk);
    check($sformatf("ticks_per_frame[%0d]", idx), tick_count - t0, 1);
    check($sformatf("sb_drained[%0d]", idx), sb_q.size(), 0);
    sb_q.delete();
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_sel"}, int'(screen_sel), 0);
    check({tag, "_score_l"}, int'(score_l), 0);
    check({tag, "_score_r"}, int'(score_r), 0);
    check({tag, "_time_left"}, int'(time_left), 3);
    check({tag, "_winner"}, int'(winner), 0);
    check({tag, "_frame_tick"}, int'(frame_tick), 0);
  endtask

  task automatic tick9;
    vsync2 = 1'b0;
    @(negedge clk);
    check("dut9_tick", int'(frame_tick2), 1);
    @(negedge clk);
    vsync2 = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Idle frames in TITLE
    for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 0, 0, 0, 3, 0);
    // Pause in TITLE is dropped by the per-frame clear; start enters PLAY
    add(0, 1, 0, 0, 0, 0, 0, 3, 0);
    add(1, 0, 0, 0, 1, 0, 0, 3, 0);
    add(0, 0, 0, 0, 1, 0, 0, 3, 0);
    add(0, 0, 0, 0, 1, 0, 0, 2, 0);
    // Left reaches WIN_SCORE, right goal in OVER ignored, hold then exit
    add(0, 0, 2, 0, 3, 2, 0, 2, 1);
    add(0, 0, 0, 1, 3, 2, 0, 2, 1);
    add(0, 0, 0, 0, 3, 2, 0, 2, 1);
    add(0, 0, 0, 0, 3, 2, 0, 2, 1);
    add(1, 0, 0, 0, 3, 2, 0, 2, 1);
    add(1, 0, 0, 0, 0, 2, 0, 2, 1);
    // Pause freezes the clock, then time expires at 0:0
    add(1, 0, 0, 0, 1, 0, 0, 3, 0);
    add(0, 1, 0, 0, 2, 0, 0, 3, 0);
    for (int i = 0; i < 5; i++) add(0, 0, 0, 0, 2, 0, 0, 3, 0);
    add(0, 1, 0, 0, 1, 0, 0, 3, 0);
    add(0, 0, 0, 0, 1, 0, 0, 2, 0);
    add(0, 0, 0, 0, 1, 0, 0, 2, 0);
    add(0, 0, 0, 0, 1, 0, 0, 1, 0);
    add(0, 0, 0, 0, 1, 0, 0, 1, 0);
    add(0, 0, 0, 0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 3, 0, 0, 0, 3);
    // Early start in OVER is discarded, late one returns to TITLE
    add(0, 0, 0, 0, 3, 0, 0, 0, 3);
    add(1, 0, 0, 0, 3, 0, 0, 0, 3);
    add(0, 0, 0, 0, 3, 0, 0, 0, 3);
    add(0, 0, 0, 0, 3, 0, 0, 0, 3);
    add(1, 0, 0, 0, 0, 0, 0, 0, 3);
    // New match, simultaneous goals reach 1:1
    add(1, 0, 0, 0, 1, 0, 0, 3, 0);
    add(0, 0, 1, 1, 1, 1, 1, 3, 0);
    // After mid-match reset
    add(0, 0, 0, 0, 0, 0, 0, 3, 0);

    repeat (3) @(negedge clk);
    check_reset_state("reset");
    rst = 1'b1;

    for (int i = 0; i < vq.size() - 1; i++) run_frame(vq[i], i);

    // Synchronous reset in the middle of a 1:1 match
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_state("mid_reset");
    rst = 1'b1;
    last_sel = 0;
    run_frame(vq[vq.size() - 1], vq.size() - 1);

    // WIN_SCORE=9 build: saturation at 9:9 with simultaneous goals
    rst2 = 1'b1;
    repeat (2) @(negedge clk);
    btn_start2 = 1'b1;
    repeat (2) @(negedge clk);
    btn_start2 = 1'b0;
    tick9();
    check("dut9_sel_play", int'(screen_sel2), 1);
    for (int i = 0; i < 10; i++) begin
      goal_l2 = 1'b1;
      goal_r2 = 1'b1;
      @(negedge clk);
      goal_l2 = 1'b0;
      goal_r2 = 1'b0;
      @(negedge clk);
    end
    check("dut9_score_l_sat", int'(score_l2), 9);
    check("dut9_score_r_sat", int'(score_r2), 9);
    check("dut9_sel_still_play", int'(screen_sel2), 1);
    tick9();
    $display("dut9: sel=%0d score=%0d:%0d time=%0d winner=%0d",
             screen_sel2, score_l2, score_r2, time_left2, winner2);
    check("dut9_sel_over", int'(screen_sel2), 3);
    check("dut9_winner_draw", int'(winner2), 3);
    check("dut9_score_l_end", int'(score_l2), 9);
    check("dut9_score_r_end", int'(score_r2), 9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
